// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch sequencer; owns the PC, fetches opcode/operand words from IMEM.
// Optional macro FETCH_TIMEOUT_EN adds an ack timeout that halts with a sticky fetch_err.
module fetch_seq #(
    parameter int unsigned       ADDR_W      = 10,
    parameter int unsigned       INST_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned       TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] imem_data,
    output logic              opcode_update,
    output logic              imem_update,
    output logic [ADDR_W-1:0] pc,
    input  logic              need_operand,
    input  logic              exec_done,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt,
    output logic              busy,
    output logic              fetch_err,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ_OP   = 3'd1,
        S_LOAD_OP  = 3'd2,
        S_DECODE   = 3'd3,
        S_REQ_ARG  = 3'd4,
        S_LOAD_ARG = 3'd5,
        S_EXEC     = 3'd6,
        S_HALTED   = 3'd7
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INST_W-1:0]   r_data;
    logic                r_opcode_update;
    logic                r_imem_update;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                r_fetch_err;
    assign fetch_err = r_fetch_err;
`else
    logic                w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYC;
    assign fetch_err        = 1'b0;
`endif

    // Handshake: imem_req is high for every cycle spent in REQ_OP/REQ_ARG with imem_addr held
    // at pc; a word is accepted in any cycle where imem_req and imem_ack are both high,
    // including the first request cycle. imem_ack in any other state is ignored.
    assign imem_req      = (r_state == S_REQ_OP) || (r_state == S_REQ_ARG);
    assign imem_addr     = r_pc;
    assign pc            = r_pc;
    assign imem_data     = r_data;
    assign opcode_update = r_opcode_update;
    assign imem_update   = r_imem_update;
    assign busy          = (r_state != S_IDLE) && (r_state != S_HALTED);
    assign dbg_state     = r_state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_pc            <= RESET_PC;
            r_data          <= '0;
            r_opcode_update <= 1'b0;
            r_imem_update   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_wait_cnt      <= '0;
            r_fetch_err     <= 1'b0;
`endif
        end else begin
            r_opcode_update <= 1'b0;
            r_imem_update   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_wait_cnt      <= '0;
`endif
            case (r_state)
                S_IDLE: r_state <= S_REQ_OP;
                S_REQ_OP, S_REQ_ARG: begin
                    if (imem_ack) begin
                        r_data <= imem_rdata;
                        r_pc   <= r_pc + ADDR_W'(1);
                        if (r_state == S_REQ_OP) begin
                            r_state         <= S_LOAD_OP;
                            r_opcode_update <= 1'b1;
                        end else begin
                            r_state       <= S_LOAD_ARG;
                            r_imem_update <= 1'b1;
                        end
                    end
`ifdef FETCH_TIMEOUT_EN
                    // A late ack on the final allowed cycle is taken above, so it wins over timeout.
                    else if (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        r_state     <= S_HALTED;
                        r_fetch_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
`endif
                end
                S_LOAD_OP: r_state <= S_DECODE;
                S_DECODE: r_state <= need_operand ? S_REQ_ARG : S_EXEC;
                S_LOAD_ARG: r_state <= S_EXEC;
                S_EXEC: begin
                    if (exec_done) begin
                        if (halt) begin
                            r_state <= S_HALTED;
                        end else begin
                            if (jump_en) r_pc <= jump_addr;
                            r_state <= S_REQ_OP;
                        end
                    end
                end
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed bench for fetch_seq with an IMEM responder and an update scoreboard.
module tb_fetch_seq;
    localparam int W = 27;
    localparam logic [2:0] S_IDLE = 3'd0, S_REQ_OP = 3'd1, S_REQ_ARG = 3'd4;
    localparam logic [2:0] S_EXEC = 3'd6, S_HALTED = 3'd7;

    logic        clk, rst;
    logic        imem_req, imem_ack;
    logic [9:0]  imem_addr, pc, jump_addr;
    logic [15:0] imem_rdata, imem_data;
    logic        opcode_update, imem_update, need_operand, exec_done, jump_en, halt;
    logic        busy, fetch_err;
    logic [2:0]  dbg_state;

    logic [W-1:0] exp_q[$];
    logic [15:0]  mem [0:1023];
    int           n_tests = 0;
    int           n_fail = 0;
    int           ack_lat = 0;
    bit           mute = 0;
    bit           force_ack = 0;
    int           c;

    fetch_seq #(.ADDR_W(10), .INST_W(16), .RESET_PC(10'd0), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_data(imem_data),
        .opcode_update(opcode_update), .imem_update(imem_update), .pc(pc),
        .need_operand(need_operand), .exec_done(exec_done), .jump_en(jump_en),
        .jump_addr(jump_addr), .halt(halt), .busy(busy), .fetch_err(fetch_err),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // IMEM responder: acks after ack_lat waiting cycles; driven 2 time units after the edge
    initial begin
        int wait_n;
        wait_n = 0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (force_ack) begin
                imem_ack = 1'b1;
                imem_rdata = 16'hDEAD;
            end else if (imem_req && !mute) begin
                if (wait_n >= ack_lat) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem[imem_addr];
                    wait_n = 0;
                end else begin
                    imem_ack = 1'b0;
                    wait_n++;
                end
            end else begin
                imem_ack = 1'b0;
                wait_n = 0;
            end
        end
    end

    // scoreboard monitor: pops one expected {is_operand, word, pc} per update pulse
    initial begin
        logic [W-1:0] e;
        logic [9:0]   prev_addr;
        bit           prev_wait;
        prev_wait = 0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_wait = 0;
            end else begin
                if (opcode_update || imem_update) begin
                    check("no_overlap", 32'(opcode_update & imem_update), 32'd0);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_update: got data 0x%0h pc 0x%0h with nothing expected",
                                 imem_data, pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("update", 32'({imem_update, imem_data, pc}), 32'(e));
                    end
                end
                if (imem_req && prev_wait) check("addr_stable", 32'(imem_addr), 32'(prev_addr));
                prev_wait = imem_req && !imem_ack;
                prev_addr = imem_addr;
            end
        end
    end

    // driver tasks
    task automatic push_exp(input logic k, input logic [15:0] d, input logic [9:0] p);
        exp_q.push_back({k, d, p});
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output int cycles);
        cycles = 0;
        while (dbg_state != s && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (dbg_state != s) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_state: got state %0d expected %0d within %0d cycles", dbg_state, s, budget);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        need_operand = 1'b0;
        exec_done = 1'b0;
        jump_en = 1'b0;
        halt = 1'b0;
        jump_addr = '0;
        ack_lat = 0;
        mute = 0;
        force_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // fetch mem[0] as a no-operand instruction, then jump so the next fetch starts at a
    task automatic start_at(input logic [9:0] a);
        int n;
        do_reset();
        push_exp(1'b0, mem[0], 10'd1);
        wait_state(S_EXEC, 20, n);
        jump_addr = a;
        jump_en = 1'b1;
        exec_done = 1'b1;
        @(posedge clk);
        #1;
        exec_done = 1'b0;
        jump_en = 1'b0;
        check("start_addr", 32'(imem_addr), 32'(a));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 7 + 3);
        mem[0] = 16'h1234;
        mem[5] = 16'hA001;
        mem[6] = 16'h00FF;
        mem[8] = 16'h4E71;
        mem[10'h10] = 16'h5A5A;
        mem[10'h11] = 16'h6B6B;
        mem[10'h3FF] = 16'hC3C3;

        // 1: reset values, IDLE lasts one cycle, zero-wait fetch of 0x1234
        rst = 1'b0;
        need_operand = 1'b0; exec_done = 1'b0; jump_en = 1'b0; halt = 1'b0; jump_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_data", 32'(imem_data), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_upd", 32'({opcode_update, imem_update}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        push_exp(1'b0, 16'h1234, 10'd1);
        rst = 1'b1;
        @(negedge clk);
        check("idle_no_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", 32'(imem_addr), 32'd0);
        check("busy_req", 32'(busy), 32'd1);
        wait_state(S_EXEC, 10, c);
        check("lat_no_arg", 32'(c), 32'd3);
        check("t1_pc", 32'(pc), 32'd1);
        exec_done = 1'b1;
        @(posedge clk);
        #1;
        exec_done = 1'b0;
        mute = 1;
        check("t1_next_state", 32'(dbg_state), 32'(S_REQ_OP));
        check("t1_next_addr", 32'(imem_addr), 32'd1);
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // 2: opcode + operand with 3-cycle ack delay
        start_at(10'd5);
        ack_lat = 3;
        need_operand = 1'b1;
        push_exp(1'b0, 16'hA001, 10'd6);
        push_exp(1'b1, 16'h00FF, 10'd7);
        wait_state(S_EXEC, 30, c);
        check("lat_slow_arg", 32'(c), 32'd11);
        check("t2_pc", 32'(pc), 32'd7);
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // 3a: EXEC holds, then taken jump to 0x200
        start_at(10'd8);
        push_exp(1'b0, 16'h4E71, 10'd9);
        wait_state(S_EXEC, 10, c);
        check("t3_pc", 32'(pc), 32'd9);
        @(posedge clk);
        #1;
        check("exec_hold", 32'(dbg_state), 32'(S_EXEC));
        check("exec_busy", 32'(busy), 32'd1);
        jump_addr = 10'h200; jump_en = 1'b1; exec_done = 1'b1;
        @(posedge clk);
        #1;
        exec_done = 1'b0; jump_en = 1'b0; mute = 1;
        check("jump_addr", 32'(imem_addr), 32'h200);
        check("jump_state", 32'(dbg_state), 32'(S_REQ_OP));

        // 3b: halt has priority over jump
        start_at(10'd8);
        push_exp(1'b0, 16'h4E71, 10'd9);
        wait_state(S_EXEC, 10, c);
        halt = 1'b1; jump_en = 1'b1; jump_addr = 10'h200; exec_done = 1'b1;
        @(posedge clk);
        #1;
        check("halt_state", 32'(dbg_state), 32'(S_HALTED));
        check("halt_pc", 32'(pc), 32'd9);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_req", 32'(imem_req), 32'd0);
        halt = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("halt_stays", 32'(dbg_state), 32'(S_HALTED));
        check("halt_pc_hold", 32'(pc), 32'd9);
        check("halt_no_req", 32'(imem_req), 32'd0);
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // 4: PC wrap from 0x3FF, operand fetched at 0x000
        start_at(10'h3FF);
        need_operand = 1'b1;
        push_exp(1'b0, 16'hC3C3, 10'h000);
        push_exp(1'b1, 16'h1234, 10'h001);
        wait_state(S_REQ_ARG, 10, c);
        check("wrap_addr", 32'(imem_addr), 32'd0);
        wait_state(S_EXEC, 10, c);
        check("wrap_pc", 32'(pc), 32'd1);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // 5: reset lands in REQ_ARG while ack arrives; stale ack across IDLE is dropped
        start_at(10'h10);
        need_operand = 1'b1;
        push_exp(1'b0, 16'h5A5A, 10'h11);
        wait_state(S_REQ_ARG, 10, c);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_pc", 32'(pc), 32'd0);
        check("mid_rst_data", 32'(imem_data), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_upd", 32'({opcode_update, imem_update}), 32'd0);
        force_ack = 1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        force_ack = 0;
        mute = 1;
        check("stale_ack_state", 32'(dbg_state), 32'(S_REQ_OP));
        check("stale_ack_data", 32'(imem_data), 32'd0);
        check("stale_ack_pc", 32'(pc), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_still_req", 32'(dbg_state), 32'(S_REQ_OP));
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // 6: ack never arrives
        do_reset();
        mute = 1;
`ifdef FETCH_TIMEOUT_EN
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("tmo_waiting", 32'({dbg_state, fetch_err}), 32'({S_REQ_OP, 1'b0}));
        end
        @(posedge clk);
        #1;
        check("tmo_state", 32'(dbg_state), 32'(S_HALTED));
        check("tmo_err", 32'(fetch_err), 32'd1);
        check("tmo_req", 32'(imem_req), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("tmo_sticky", 32'(fetch_err), 32'd1);
        do_reset();
        ack_lat = 3;
        push_exp(1'b0, 16'h1234, 10'd1);
        wait_state(S_EXEC, 20, c);
        check("tmo_late_ack_lat", 32'(c), 32'd7);
        check("tmo_late_ack_err", 32'(fetch_err), 32'd0);
`else
        repeat (20) @(posedge clk);
        #1;
        check("wait_forever_state", 32'(dbg_state), 32'(S_REQ_OP));
        check("wait_forever_req", 32'(imem_req), 32'd1);
        check("wait_forever_err", 32'(fetch_err), 32'd0);
`endif
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Instruction fetch sequencer that sits directly upstream of the register bank.
- Owns the program counter and reads instruction words from IMEM over a req/ack handshake.
- Forwards each word with a one-cycle `opcode_update` or `imem_update` pulse, then fetches an operand word when the decoder asks for one.
- Holds in execute until the execute/control stage signals completion; applies jumps and halt at that point.

Parameters:
- ADDR_W, 10, PC and IMEM address width.
- INST_W, 16, instruction word width.
- RESET_PC, 0, PC value loaded at reset.
- TIMEOUT_CYC, 255, maximum cycles to wait for ack; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; always equals pc.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  INST_W  read word.
- imem_data  out  INST_W  registered captured word, to the register bank.
- opcode_update  out  1  one-cycle pulse: imem_data is an opcode.
- imem_update  out  1  one-cycle pulse: imem_data is an operand.
- pc  out  ADDR_W  program counter.
- need_operand  in  1  decoder: current opcode needs an operand word.
- exec_done  in  1  execute stage finished the current instruction.
- jump_en  in  1  taken jump; sampled only with exec_done.
- jump_addr  in  ADDR_W  jump target.
- halt  in  1  stop fetching; sampled only with exec_done.
- busy  out  1  high in every state except IDLE and HALTED.
- fetch_err  out  1  sticky fetch timeout flag.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, pc=RESET_PC, imem_data=0.
  - imem_req, opcode_update, imem_update, busy and fetch_err all 0.
- States: IDLE, REQ_OP, LOAD_OP, DECODE, REQ_ARG, LOAD_ARG, EXEC, HALTED.
- IDLE:
  - Lasts exactly one cycle after reset, then goes to REQ_OP.
  - imem_ack is ignored here, so a stale ack from before reset is dropped.
- imem_req is high combinationally in REQ_OP and REQ_ARG, low elsewhere.
- imem_addr is held stable while imem_req is high.
- Ack in the same cycle as the request is legal (zero-wait memory).
- REQ_OP:
  - On imem_ack: imem_data<=imem_rdata, pc<=pc+1 (mod 2^ADDR_W; 0x3FF wraps to 0x000), go to LOAD_OP.
  - Otherwise stay.
- LOAD_OP: opcode_update=1 for this cycle only; go to DECODE.
- DECODE:
  - need_operand is sampled here; it is valid because the register bank latched the opcode at the end of LOAD_OP.
  - need_operand=1: go to REQ_ARG. need_operand=0: go to EXEC.
- REQ_ARG: same as REQ_OP but goes to LOAD_ARG; pc increments again.
- LOAD_ARG: imem_update=1 for this cycle only; go to EXEC.
- EXEC: wait for exec_done. On exec_done:
  - halt=1: go to HALTED with pc unchanged; halt has priority over jump_en.
  - else jump_en=1: pc<=jump_addr, go to REQ_OP.
  - else: go to REQ_OP with pc unchanged; it already points past the instruction.
- HALTED: absorbing; only reset leaves it. imem_req=0.
- imem_ack outside REQ_OP/REQ_ARG is ignored.
- exec_done, jump_en and halt are ignored outside EXEC.
- Latency, zero-wait memory:
  - Instruction without operand: REQ_OP to opcode_update pulse is 1 cycle; earliest next REQ_OP is 4 cycles after the previous one (exec_done high on entering EXEC).
  - Instruction with operand: 6 cycles.
- Reset mid-operation: the request drops at the same edge and any captured word is discarded.
- opcode_update and imem_update are never high in the same cycle.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider wait counter clears on entering REQ_OP/REQ_ARG and increments each cycle without ack.
  - When the counter reaches TIMEOUT_CYC without ack: imem_req drops next cycle, fetch_err<=1 (sticky until reset), state goes to HALTED.
  - An ack arriving in the same cycle the counter reaches TIMEOUT_CYC wins: the word is accepted and there is no error.
- Not defined: no counter, waits for ack indefinitely, fetch_err tied to 0.

Test Plan:
1. Reset then zero-wait memory, word 0x1234 at addr 0, need_operand=0, exec_done=1:
   - imem_req first high 1 cycle after reset release.
   - opcode_update pulses once with imem_data=0x1234; pc=1.
   - next imem_addr=1.
2. need_operand=1, words 0xA001@5, 0x00FF@6, ack delayed 3 cycles each:
   - opcode_update with 0xA001, then imem_update with 0x00FF.
   - pc=7 in EXEC; imem_addr stable during each wait.
3. In EXEC at pc=9: exec_done=1, jump_en=1, jump_addr=0x200 -> next request at 0x200.
   - Same setup with halt=1 also set -> HALTED, pc stays 9, no further req, busy=0.
4. pc=0x3FF fetch with operand -> operand fetched at 0x000, pc=0x001 after the operand.
5. Reset asserted in REQ_ARG with ack arriving that same cycle:
   - word discarded, pc=RESET_PC, no update pulse.
   - ack held high during IDLE is ignored.
6. FETCH_TIMEOUT_EN, TIMEOUT_CYC=4, ack never arrives:
   - fetch_err=1 and HALTED after 4 request cycles.
   - Separate run with ack on the 4th cycle: word accepted, fetch_err=0.
